// File: rtl/i2c_target_regs.sv
// I2C target at a 7-bit address with a 4x16-bit register map; open-drain SDA, never stretches SCL.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample persistence filter on both lines.
module i2c_target_regs #(
   parameter logic [6:0]  ADDR    = 7'h48,
   parameter logic [15:0] CFG_RST = 16'h8583
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_scl,
   input  logic        i_sda,
   output logic        o_sda_oe,
   input  logic [15:0] i_conv_data,
   output logic [15:0] o_config,
   output logic [15:0] o_lo_thresh,
   output logic [15:0] o_hi_thresh,
   output logic        o_wr_stb,
   output logic [1:0]  o_wr_ptr,
   output logic        o_rd_stb,
   output logic        o_busy
);

   // state | meaning: IDLE wait START; ADDR/PTR/WMSB/WLSB shift a byte in; *_ACK drive ACK;
   // RD shift a byte out; RD_ACK sample controller ACK; IGNORE wait for START/STOP
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ADDR     = 4'd1;
   localparam logic [3:0] S_ADDR_ACK = 4'd2;
   localparam logic [3:0] S_PTR      = 4'd3;
   localparam logic [3:0] S_PTR_ACK  = 4'd4;
   localparam logic [3:0] S_WMSB     = 4'd5;
   localparam logic [3:0] S_WMSB_ACK = 4'd6;
   localparam logic [3:0] S_WLSB     = 4'd7;
   localparam logic [3:0] S_WLSB_ACK = 4'd8;
   localparam logic [3:0] S_RD       = 4'd9;
   localparam logic [3:0] S_RD_ACK   = 4'd10;
   localparam logic [3:0] S_IGNORE   = 4'd11;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_l, sda_l;
   logic       scl_prev_q, sda_prev_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], i_scl};
         sda_sync_q <= {sda_sync_q[0], i_sda};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q, sda_hist_q;
   logic       scl_flt_q, sda_flt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_flt_q  <= 1'b1;
         sda_flt_q  <= 1'b1;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
         if (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1])
            scl_flt_q <= scl_sync_q[1];
         if (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1])
            sda_flt_q <= sda_sync_q[1];
      end
   end

   assign scl_l = scl_flt_q;
   assign sda_l = sda_flt_q;
`else
   assign scl_l = scl_sync_q[1];
   assign sda_l = sda_sync_q[1];
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_l;
         sda_prev_q <= sda_l;
      end
   end

   logic start, stop, scl_rise, scl_fall;
   assign start    = scl_l & scl_prev_q & sda_prev_q & ~sda_l;
   assign stop     = scl_l & scl_prev_q & ~sda_prev_q & sda_l;
   assign scl_rise = scl_l & ~scl_prev_q;
   assign scl_fall = ~scl_l & scl_prev_q;

   logic [3:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [6:0]  sh_q, sh_d;
   logic [15:0] tx_q, tx_d;
   logic [7:0]  msb_q, msb_d;
   logic [1:0]  ptr_q, ptr_d;
   logic        rw_q, rw_d;
   logic        rd_lsb_q, rd_lsb_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        wr_stb_q, wr_stb_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic        rd_stb_q, rd_stb_d;
   logic [15:0] cfg_q, cfg_d;
   logic [15:0] lo_q, lo_d;
   logic [15:0] hi_q, hi_d;
   logic [15:0] snap;
   logic [7:0]  rx_byte;

   always_comb begin
      case (ptr_q)
         2'd0:    snap = i_conv_data;
         2'd1:    snap = cfg_q;
         2'd2:    snap = lo_q;
         default: snap = hi_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      tx_d     = tx_q;
      msb_d    = msb_q;
      ptr_d    = ptr_q;
      rw_d     = rw_q;
      rd_lsb_d = rd_lsb_q;
      sda_oe_d = sda_oe_q;
      busy_d   = busy_q;
      wr_ptr_d = wr_ptr_q;
      cfg_d    = cfg_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
      rx_byte  = {sh_q, sda_l};

      if (start) begin
         state_d  = S_ADDR;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else if (stop) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_PTR, S_WMSB, S_WLSB: begin
               if (scl_rise) begin
                  sh_d  = rx_byte[6:0];
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = 4'd0;
                     if (state_q == S_ADDR) begin
                        if (rx_byte[7:1] != ADDR) begin
                           state_d = S_IGNORE;
                           busy_d  = 1'b0;
                        end else begin
                           state_d = S_ADDR_ACK;
                           busy_d  = 1'b1;
                           rw_d    = rx_byte[0];
                           if (rx_byte[0]) begin
                              tx_d     = snap;
                              rd_lsb_d = 1'b0;
                              rd_stb_d = (ptr_q == 2'd0);
                           end
                        end
                     end else if (state_q == S_PTR) begin
                        ptr_d   = rx_byte[1:0];
                        state_d = S_PTR_ACK;
                     end else if (state_q == S_WMSB) begin
                        msb_d   = rx_byte;
                        state_d = S_WMSB_ACK;
                     end else begin
                        // register 0 is read-only: the byte is ACKed but dropped
                        case (ptr_q)
                           2'd1:    cfg_d = {msb_q, rx_byte};
                           2'd2:    lo_d  = {msb_q, rx_byte};
                           2'd3:    hi_d  = {msb_q, rx_byte};
                           default: ;
                        endcase
                        if (ptr_q != 2'd0) begin
                           wr_stb_d = 1'b1;
                           wr_ptr_d = ptr_q;
                        end
                        state_d = S_WLSB_ACK;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WMSB_ACK, S_WLSB_ACK: begin
               if (scl_fall) begin
                  if (cnt_q == 4'd0) begin
                     sda_oe_d = 1'b1;
                     cnt_d    = 4'd1;
                  end else begin
                     cnt_d    = 4'd0;
                     sda_oe_d = 1'b0;
                     if (state_q == S_ADDR_ACK) begin
                        if (rw_q) begin
                           state_d  = S_RD;
                           sda_oe_d = ~tx_q[15];
                           tx_d     = {tx_q[14:0], 1'b0};
                        end else begin
                           state_d = S_PTR;
                        end
                     end else if (state_q == S_PTR_ACK) begin
                        state_d = S_WMSB;
                     end else if (state_q == S_WMSB_ACK) begin
                        state_d = S_WLSB;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end
               end
            end
            S_RD: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     cnt_d    = 4'd0;
                     state_d  = S_RD_ACK;
                  end else begin
                     sda_oe_d = ~tx_q[15];
                     tx_d     = {tx_q[14:0], 1'b0};
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise && cnt_q == 4'd0) begin
                  if (sda_l) begin
                     state_d = S_IGNORE;
                  end else begin
                     cnt_d = 4'd1;
                     if (!rd_lsb_q) begin
                        rd_lsb_d = 1'b1;
                     end else begin
                        tx_d     = snap;
                        rd_lsb_d = 1'b0;
                        rd_stb_d = (ptr_q == 2'd0);
                     end
                  end
               end else if (scl_fall && cnt_q == 4'd1) begin
                  sda_oe_d = ~tx_q[15];
                  tx_d     = {tx_q[14:0], 1'b0};
                  cnt_d    = 4'd0;
                  state_d  = S_RD;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         sh_q     <= 7'd0;
         tx_q     <= 16'd0;
         msb_q    <= 8'd0;
         ptr_q    <= 2'd0;
         rw_q     <= 1'b0;
         rd_lsb_q <= 1'b0;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         wr_stb_q <= 1'b0;
         wr_ptr_q <= 2'd0;
         rd_stb_q <= 1'b0;
         cfg_q    <= CFG_RST;
         lo_q     <= 16'h8000;
         hi_q     <= 16'h7FFF;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         tx_q     <= tx_d;
         msb_q    <= msb_d;
         ptr_q    <= ptr_d;
         rw_q     <= rw_d;
         rd_lsb_q <= rd_lsb_d;
         sda_oe_q <= sda_oe_d;
         busy_q   <= busy_d;
         wr_stb_q <= wr_stb_d;
         wr_ptr_q <= wr_ptr_d;
         rd_stb_q <= rd_stb_d;
         cfg_q    <= cfg_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

   assign o_sda_oe    = sda_oe_q;
   assign o_busy      = busy_q;
   assign o_wr_stb    = wr_stb_q;
   assign o_wr_ptr    = wr_ptr_q;
   assign o_rd_stb    = rd_stb_q;
   assign o_config    = cfg_q;
   assign o_lo_thresh = lo_q;
   assign o_hi_thresh = hi_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: a bus master issues directed transfers and pushes
// expected frames/strobes/register values; a monitor process pops and compares them.
module tb_i2c_target_regs;

   localparam logic [3:0] K_CFG = 4'd0, K_LO = 4'd1, K_HI = 4'd2, K_BUSY = 4'd3;
   localparam logic [3:0] K_WRPTR = 4'd4, K_OE = 4'd5, K_DRAIN = 4'd6, K_NODRV = 4'd7;

   typedef struct packed { logic [3:0] kind; logic [15:0] exp; } chk_t;
   typedef struct packed { logic [1:0] ptr; logic [15:0] val; } wr_t;

   logic        clk, rst, scl_m, sda_m, sda_bus;
   logic        sda_oe, wr_stb, rd_stb, busy;
   logic [15:0] conv, cfg, lo, hi;
   logic [1:0]  wr_ptr;
   logic        forbid;

   chk_t       chk_q[$];
   wr_t        wr_q[$];
   logic [8:0] frame_q[$];
   logic       rd_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_target_regs dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_scl       (scl_m),
      .i_sda       (sda_bus),
      .o_sda_oe    (sda_oe),
      .i_conv_data (conv),
      .o_config    (cfg),
      .o_lo_thresh (lo),
      .o_hi_thresh (hi),
      .o_wr_stb    (wr_stb),
      .o_wr_ptr    (wr_ptr),
      .o_rd_stb    (rd_stb),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] reg_by(input logic [1:0] p);
      case (p)
         2'd1:    return cfg;
         2'd2:    return lo;
         2'd3:    return hi;
         default: return conv;
      endcase
   endfunction

   initial begin
      logic       scl_p, sda_p, in_xfer, oe_seen;
      logic [8:0] frame, ef;
      int         nbits;
      chk_t       c;
      wr_t        w;
      scl_p = 1'b1; sda_p = 1'b1; in_xfer = 1'b0; oe_seen = 1'b0;
      frame = '0; nbits = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_xfer = 1'b0;
            nbits   = 0;
         end else if (scl_m && scl_p && sda_p && !sda_bus) begin
            in_xfer = 1'b1;
            nbits   = 0;
         end else if (scl_m && scl_p && !sda_p && sda_bus) begin
            in_xfer = 1'b0;
            nbits   = 0;
         end else if (scl_m && !scl_p && in_xfer) begin
            frame = {frame[7:0], sda_bus};
            nbits++;
            if (nbits == 9) begin
               nbits = 0;
               if (frame_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL frame: unexpected frame %h", frame);
               end else begin
                  ef = frame_q.pop_front();
                  check("frame byte+ack", {7'd0, frame}, {7'd0, ef});
               end
            end
         end
         scl_p = scl_m;
         sda_p = sda_bus;

         if (forbid && sda_oe) oe_seen = 1'b1;

         if (wr_stb) begin
            if (wr_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL wr_stb: unexpected strobe, wr_ptr %0d", wr_ptr);
            end else begin
               w = wr_q.pop_front();
               check("wr_ptr", {14'd0, wr_ptr}, {14'd0, w.ptr});
               check("wr_value", reg_by(w.ptr), w.val);
            end
         end
         if (rd_stb) begin
            if (rd_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL rd_stb: unexpected strobe");
            end else begin
               void'(rd_q.pop_front());
            end
         end

         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.kind)
               K_CFG:   check("config", cfg, c.exp);
               K_LO:    check("lo_thresh", lo, c.exp);
               K_HI:    check("hi_thresh", hi, c.exp);
               K_BUSY:  check("busy", {15'd0, busy}, c.exp);
               K_WRPTR: check("wr_ptr reg", {14'd0, wr_ptr}, c.exp);
               K_OE:    check("sda_oe", {15'd0, sda_oe}, c.exp);
               K_NODRV: begin
                  check("sda never driven", {15'd0, oe_seen}, c.exp);
                  oe_seen = 1'b0;
               end
               default: begin
                  check("frames pending", 16'(frame_q.size()), c.exp);
                  check("wr_stb pending", 16'(wr_q.size()), c.exp);
                  check("rd_stb pending", 16'(rd_q.size()), c.exp);
               end
            endcase
         end
      end
   end

   // ---------------- bus master ----------------
   task automatic qtr();
      repeat (10) @(posedge clk);
   endtask

   task automatic expect_val(input logic [3:0] k, input logic [15:0] v);
      chk_q.push_back({k, v});
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; qtr();
      scl_m = 1'b1; qtr();
      sda_m = 1'b0; qtr();
      scl_m = 1'b0; qtr();
   endtask

   task automatic i2c_stop();
      scl_m = 1'b0; qtr();
      sda_m = 1'b0; qtr();
      scl_m = 1'b1; qtr();
      sda_m = 1'b1; qtr(); qtr();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    qtr();
      scl_m = 1'b1; qtr(); qtr();
      scl_m = 1'b0; qtr();
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
      frame_q.push_back({b, exp_ack});
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      send_bit(1'b1);
   endtask

   task automatic rd_byte(input logic [7:0] exp_b, input logic m_ack);
      frame_q.push_back({exp_b, m_ack});
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      send_bit(m_ack);
   endtask

   task automatic rst_pulse();
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; conv = 16'h0000; forbid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      expect_val(K_CFG, 16'h8583);
      expect_val(K_LO, 16'h8000);
      expect_val(K_HI, 16'h7FFF);
      expect_val(K_BUSY, 16'd0);
      expect_val(K_WRPTR, 16'd0);
      expect_val(K_OE, 16'd0);

      // config write
      i2c_start();
      wr_byte(8'h90, 1'b0);
      expect_val(K_BUSY, 16'd1);
      wr_byte(8'h01, 1'b0);
      wr_q.push_back({2'd1, 16'hC383});
      wr_byte(8'hC3, 1'b0);
      wr_byte(8'h83, 1'b0);
      i2c_stop();
      expect_val(K_CFG, 16'hC383);
      expect_val(K_WRPTR, 16'd1);
      expect_val(K_BUSY, 16'd0);

      // pointer 0 then repeated-START read of the conversion value
      conv = 16'h1234;
      i2c_start();
      wr_byte(8'h90, 1'b0);
      wr_byte(8'h00, 1'b0);
      i2c_start();
      rd_q.push_back(1'b1);
      wr_byte(8'h91, 1'b0);
      rd_byte(8'h12, 1'b0);
      rd_byte(8'h34, 1'b1);
      expect_val(K_BUSY, 16'd1);
      i2c_stop();
      expect_val(K_BUSY, 16'd0);

      // foreign address: no ACK, nothing changes
      forbid = 1'b1;
      i2c_start();
      wr_byte(8'h94, 1'b1);
      expect_val(K_BUSY, 16'd0);
      wr_byte(8'h02, 1'b1);
      wr_byte(8'hAA, 1'b1);
      wr_byte(8'hBB, 1'b1);
      i2c_stop();
      forbid = 1'b0;
      expect_val(K_NODRV, 16'd0);
      expect_val(K_CFG, 16'hC383);
      expect_val(K_LO, 16'h8000);
      expect_val(K_WRPTR, 16'd1);

      // pointer 3 after reset, controller ACKs every byte
      rst_pulse();
      expect_val(K_CFG, 16'h8583);
      i2c_start();
      wr_byte(8'h90, 1'b0);
      wr_byte(8'h03, 1'b0);
      i2c_start();
      wr_byte(8'h91, 1'b0);
      rd_byte(8'h7F, 1'b0);
      rd_byte(8'hFF, 1'b0);
      rd_byte(8'h7F, 1'b0);
      rd_byte(8'hFF, 1'b0);
      rd_byte(8'h7F, 1'b1);
      i2c_stop();

      // write to register 0 is ACKed but discarded; extra byte NACKed
      i2c_start();
      wr_byte(8'h90, 1'b0);
      wr_byte(8'h00, 1'b0);
      wr_byte(8'hAB, 1'b0);
      wr_byte(8'hCD, 1'b0);
      wr_byte(8'hEE, 1'b1);
      i2c_stop();
      expect_val(K_WRPTR, 16'd0);
      expect_val(K_HI, 16'h7FFF);

      // register 0 snapshots: LSB comes from the first snapshot, re-snapshot after LSB ACK
      conv = 16'h5AA5;
      i2c_start();
      rd_q.push_back(1'b1);
      wr_byte(8'h91, 1'b0);
      rd_byte(8'h5A, 1'b0);
      conv = 16'hC001;
      rd_q.push_back(1'b1);
      rd_byte(8'hA5, 1'b0);
      rd_byte(8'hC0, 1'b0);
      rd_byte(8'h01, 1'b1);
      i2c_stop();

      // change config, then reset while the target drives a 0 data bit
      i2c_start();
      wr_byte(8'h90, 1'b0);
      wr_byte(8'h01, 1'b0);
      wr_q.push_back({2'd1, 16'hBEEF});
      wr_byte(8'hBE, 1'b0);
      wr_byte(8'hEF, 1'b0);
      i2c_stop();
      expect_val(K_CFG, 16'hBEEF);
      conv = 16'h00FF;
      i2c_start();
      wr_byte(8'h90, 1'b0);
      wr_byte(8'h00, 1'b0);
      i2c_start();
      rd_q.push_back(1'b1);
      wr_byte(8'h91, 1'b0);
      expect_val(K_OE, 16'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      expect_val(K_OE, 16'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      scl_m = 1'b1; sda_m = 1'b1;
      repeat (20) @(posedge clk);
      expect_val(K_CFG, 16'h8583);
      expect_val(K_WRPTR, 16'd0);
      expect_val(K_BUSY, 16'd0);

      // normal traffic after reset: write lo threshold and read it back
      i2c_start();
      wr_byte(8'h90, 1'b0);
      wr_byte(8'h02, 1'b0);
      wr_q.push_back({2'd2, 16'h0102});
      wr_byte(8'h01, 1'b0);
      wr_byte(8'h02, 1'b0);
      i2c_stop();
      expect_val(K_LO, 16'h0102);
      expect_val(K_WRPTR, 16'd2);
      i2c_start();
      wr_byte(8'h91, 1'b0);
      rd_byte(8'h01, 1'b0);
      rd_byte(8'h02, 1'b1);
      i2c_stop();

      expect_val(K_DRAIN, 16'd0);
      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) for the FPGA fabric, presenting an ADS1115-style 4×16-bit register map at a 7-bit address. An external I2C controller (MCU, or a second board running our ADS1115 polling driver) can write config/threshold registers and read a conversion value supplied by fabric logic. It sits behind open-drain SB_IO pads in a top level; the block only ever pulls SDA low and never drives SCL (no clock stretching).

## Interface
- `ADDR`, 7'h48: target address; other addresses are ignored.
- `CFG_RST`, 16'h8583: reset value of register 1 (config).
- `i_clk` in 1: system clock. It must run at ≥16× SCL; 25 MHz supports 400 kHz.
- `i_rst` in 1: one clock; reset is asynchronous and active-high.
- `i_scl` in 1: SCL pad input.
- `i_sda` in 1: SDA pad input.
- `o_sda_oe` out 1: 1 pulls SDA low; 0 releases SDA. Wire it to the pad's `OUTPUT_ENABLE` with `D_OUT_0`=0.
- `i_conv_data` in 16: value returned for register 0.
- `o_config` out 16: register 1.
- `o_lo_thresh` out 16: register 2. Reset value 16'h8000.
- `o_hi_thresh` out 16: register 3. Reset value 16'h7FFF.
- `o_wr_stb` out 1: one-cycle pulse when a register write commits.
- `o_wr_ptr` out 2: register index of the last commit.
- `o_rd_stb` out 1: one-cycle pulse when register 0 is snapshotted.
- `o_busy` out 1: high from address-match ACK until STOP or a non-matching START.

## Operation
- Input path: SCL and SDA pass through a 2-flop synchronizer, then an edge detector on the synchronized copies.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge, MSB first.
- State machine states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WMSB, WMSB_ACK, WLSB, WLSB_ACK, RD, RD_ACK, IGNORE.
- START in any state → ADDR, bit counter cleared. This covers repeated START.
- STOP in any state → IDLE. SDA is released and `o_busy` is cleared.
- ADDR: collect 8 bits.
  - If addr[7:1] ≠ `ADDR` → IGNORE, no ACK.
  - On a match → ADDR_ACK (ACK driven).
  - On a match with R/W=1, also take a snapshot of the pointed register into the shift register. Pointer 0 additionally pulses `o_rd_stb`.
- Write path:
  - ADDR_ACK with W → PTR. Byte received; pointer ← byte[1:0]; bits [7:2] are ignored → PTR_ACK → WMSB.
  - WMSB → WMSB_ACK → WLSB → WLSB_ACK.
  - At WLSB_ACK the commit happens: register[pointer] ← {msb, lsb}, `o_wr_stb`=1 for 1 cycle, `o_wr_ptr`=pointer.
  - A write to pointer 0 is ACKed but discarded: no register change and no strobe.
  - After WLSB_ACK → IGNORE. Extra bytes are NACKed.
- Read path:
  - ADDR_ACK with R → RD. Shift out 16 bits as two bytes; RD_ACK samples the controller's ACK after each byte.
  - Controller ACK after the MSB → LSB is sent.
  - Controller ACK after the LSB → re-snapshot the same register (strobe rules as above) and send MSB again.
  - Controller NACK after either byte → IGNORE with SDA released.
- The pointer persists across transactions and resets to 0.

## Timing
- Reset values:
  - `o_sda_oe`=0, `o_busy`=0, `o_wr_stb`=0, `o_rd_stb`=0, `o_wr_ptr`=0, pointer=0.
  - Registers: config=`CFG_RST`, lo=16'h8000, hi=16'h7FFF.
- Reset is asynchronous: asserting `i_rst` mid-transfer drops `o_sda_oe` in the same instant. After reset release the block waits in IDLE for a START.
- Pin-to-event latency: 3 clocks (2 sync + 1 edge).
- `o_sda_oe` changes only on the detected SCL falling edge, 1 clock after detection.
  - ACK: asserted on the falling edge ending bit 8, released on the falling edge ending bit 9.
  - Read data bit n is driven on the falling edge before its rising edge. The first MSB is driven on the falling edge ending the address ACK.
- Commit and snapshot happen on the clock after the 8th-bit rising edge of the relevant byte. The strobes are high for exactly 1 clock.
- START/STOP detection has priority over a simultaneous data-bit sample.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN` defined:
  - Each synchronized line passes through a 3-sample persistence filter. The output changes only after 3 consecutive equal samples.
  - This rejects pulses shorter than 3 clocks and makes pin-to-event latency 6 clocks.
- Undefined: 2-flop synchronizer only; latency is 3 clocks.

## Test plan
- Write 0x90 (addr 0x48 W), 0x01, 0xC3, 0x83, STOP → three ACKs plus data ACKs; `o_config`=16'hC383; one `o_wr_stb` with `o_wr_ptr`=1.
- `i_conv_data`=16'h1234; write 0x90, 0x00, repeated START, 0x91, read 2 bytes with ACK then NACK, STOP → bytes 0x12, 0x34; `o_rd_stb` pulses once; `o_busy` clears after STOP.
- Address 0x4A (byte 0x94) → SDA never pulled low for the entire transaction; all outputs unchanged.
- Read of pointer 3 after reset with controller ACK on all 4 bytes → 0x7F, 0xFF, 0x7F, 0xFF.
- Write to pointer 0 with 0xAB, 0xCD → all bytes ACKed; no `o_wr_stb`; reads of register 0 still return `i_conv_data`.
- Assert `i_rst` while the target is driving a 0 data bit → `o_sda_oe`=0 immediately; config returns to 16'h8583; a following valid transaction succeeds.
